interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 107 ++++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: IF/IE registers, fixed-priority pick and CPU handshake for five sources; INTERRUPT_EDGE_DETECT_EN selects edge-triggered requests.
// Latency: request -> IF one cycle, IF -> oIrqValid one more cycle; after an ack one blank cycle before the FSM re-arbitrates.
// Backpressure: a presented interrupt is held until iAck, or dropped back to idle if iIme falls first.
module interrupt_controller (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [4:0]  iInterruptReq,
    input  logic        iWe,
    input  logic [15:0] iAddr,
    input  logic [7:0]  iData,
    output logic [7:0]  oIf,
    output logic [7:0]  oIe,
    input  logic        iIme,
    input  logic        iAck,
    output logic        oIrqValid,
    output logic [7:0]  oVector,
    output logic        oIrqPending
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t      state, stateNext;
    logic [4:0]  ifReg, ifNext;
    logic [7:0]  ieReg;
    logic [2:0]  idx, idxNext, lowest;
    logic [4:0]  reqEvent, active;
    logic        ifWrite, ieWrite, ackTake;

`ifdef INTERRUPT_EDGE_DETECT_EN
    logic [4:0] reqPrev;

    always_ff @(posedge iClock) begin
        if (iReset) reqPrev <= '0;
        else        reqPrev <= iInterruptReq;
    end

    assign reqEvent = iInterruptReq & ~reqPrev;
`else
    assign reqEvent = iInterruptReq;
`endif

    assign active  = ifReg & ieReg[4:0];
    assign ifWrite = iWe && (iAddr == 16'hFF0F);
    assign ieWrite = iWe && (iAddr == 16'hFFFF);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        lowest = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (active[i]) lowest = 3'(i);
        end
    end

    always_comb begin
        stateNext = state;
        idxNext   = idx;
        ackTake   = 1'b0;
        case (state)
            S_IDLE: begin
                if (iIme && (|active)) begin
                    stateNext = S_REQ;
                    idxNext   = lowest;
                end
            end
            S_REQ: begin
                if (iAck) begin
                    stateNext = S_CLEAR;
                    ackTake   = 1'b1;
                end else if (!iIme) begin
                    stateNext = S_IDLE;
                end
            end
            S_CLEAR: stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // Priority on IF: ack clear > request > bus write.
    always_comb begin
        ifNext = ifWrite ? iData[4:0] : ifReg;
        ifNext = ifNext | reqEvent;
        if (ackTake) ifNext = ifNext & ~(5'b00001 << idx);
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state <= S_IDLE;
            idx   <= 3'd0;
            ifReg <= 5'd0;
            ieReg <= 8'h00;
        end else begin
            state <= stateNext;
            idx   <= idxNext;
            ifReg <= ifNext;
            if (ieWrite) ieReg <= iData;
        end
    end

    assign oIf         = {3'b111, ifReg};
    assign oIe         = ieReg;
    assign oIrqValid   = (state == S_REQ);
    assign oVector     = (state == S_REQ) ? {2'b01, idx, 3'b000} : 8'h00;
    assign oIrqPending = |active;
endmodule
